// File: rtl/seg7_pkg.sv
// Shared constants for the 8-digit multiplexed seven-segment scanner.
// Segment patterns are active-high {g,f,e,d,c,b,a}; polarity is applied by the scanner.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK_HI = 7'h00;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_polarity(input logic [6:0] pat_hi, input bit active_low);
        return active_low ? ~pat_hi : pat_hi;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-high seven-segment pattern, purely combinational.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] pattern_o
);

    always_comb begin
        pattern_o = SEG_TABLE[nibble_i];
    end

endmodule

// File: rtl/seg7_scanner.sv
// Time-multiplexed 8-digit hex display driver with shadow/staging update
// at frame boundaries and optional leading-zero blanking.
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 50000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    input  logic        upd,
    input  logic        blank_lz,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        pending,
    output logic        frame_done
);

    localparam int unsigned   PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [7:0]    AN_OFF    = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [6:0]    SEG_OFF   = ACTIVE_LOW ? ~SEG_BLANK_HI : SEG_BLANK_HI;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [31:0]   staging_q, staging_d;
    logic          pending_q, pending_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic          tick;
    logic          boundary;
    logic [3:0]    nibble;
    logic [6:0]    pattern_hi;
    logic          upper_zero;
    logic          blank;
    logic [7:0]    onehot;

    assign tick     = (presc_q == PRESC_MAX);
    assign boundary = tick && (idx_q == 3'd7);

    always_comb begin
        presc_d      = tick ? '0 : presc_q + 1'b1;
        idx_d        = tick ? idx_q + 3'd1 : idx_q;
        frame_done_d = boundary;
        shadow_d     = shadow_q;
        staging_d    = staging_q;
        pending_d    = pending_q;
        if (upd && boundary) begin
            // Fresh value wins over anything staged earlier in the frame.
            shadow_d  = din;
            pending_d = 1'b0;
        end else if (upd) begin
            staging_d = din;
            pending_d = 1'b1;
        end else if (boundary && pending_q) begin
            shadow_d  = staging_q;
            pending_d = 1'b0;
        end
    end

    // Outputs are built from next-state idx/shadow so an and seg switch together.
    assign nibble     = shadow_d[{idx_d, 2'b00} +: 4];
    assign upper_zero = ((shadow_d >> {idx_d, 2'b00}) == 32'd0);
    assign blank      = blank_lz && (idx_d != 3'd0) && upper_zero;
    assign onehot     = 8'd1 << idx_d;

    seg7_decode u_decode (
        .nibble_i  (nibble),
        .pattern_o (pattern_hi)
    );

    always_comb begin
        an_d  = ACTIVE_LOW ? ~onehot : onehot;
        seg_d = blank ? SEG_OFF : seg_polarity(pattern_hi, ACTIVE_LOW);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q      <= '0;
            idx_q        <= 3'd0;
            shadow_q     <= 32'd0;
            staging_q    <= 32'd0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            staging_q    <= staging_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// Directed bench for seg7_scanner (CLK_DIV=4, common-anode); expected digit
// slots are queued as stimulus is driven and checked as the scan reaches them.
module tb_seg7_scanner;

    localparam int unsigned CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic        upd;
    logic        blank_lz;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        pending;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scanner #(
        .CLK_DIV    (CLK_DIV),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .upd        (upd),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .pending    (pending),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       fd;
        logic       pend;
        bit         len_chk;
    } exp_t;

    exp_t       sb[$];
    int         n_pass  = 0;
    int         n_fail  = 0;
    int         n_total = 0;
    logic [7:0] cur_an;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [31:0] v, input int d, input bit blank);
        logic [3:0]  nib;
        logic [31:0] upper;
        logic [6:0]  hi;
        nib   = v[4*d +: 4];
        upper = v >> (4 * d);
        if (blank && d != 0 && upper == 32'd0) return 7'h7F;
        case (nib)
            4'h0: hi = 7'h3F;  4'h1: hi = 7'h06;  4'h2: hi = 7'h5B;  4'h3: hi = 7'h4F;
            4'h4: hi = 7'h66;  4'h5: hi = 7'h6D;  4'h6: hi = 7'h7D;  4'h7: hi = 7'h07;
            4'h8: hi = 7'h7F;  4'h9: hi = 7'h6F;  4'hA: hi = 7'h77;  4'hB: hi = 7'h7C;
            4'hC: hi = 7'h39;  4'hD: hi = 7'h5E;  4'hE: hi = 7'h79;  default: hi = 7'h71;
        endcase
        return ~hi;
    endfunction

    function automatic logic [7:0] ref_an(input int d);
        logic [7:0] oh;
        oh = 8'h01 << d;
        return ~oh;
    endfunction

    // Queue the slots for digits first..last showing v.
    task automatic push(input logic [31:0] v, input bit blank, input int first, input int last,
                        input bit pend, input bit len_first);
        for (int d = first; d <= last; d++) begin
            exp_t e;
            e.an      = ref_an(d);
            e.seg     = ref_seg(v, d, blank);
            e.fd      = (d == 0);
            e.pend    = pend;
            e.len_chk = (d != first) || len_first;
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_change(output int cyc, output int stray, output bit ok);
        cyc   = 0;
        stray = 0;
        ok    = 1'b0;
        while (cyc < 3 * CLK_DIV) begin
            step();
            cyc++;
            if (an !== cur_an) begin
                ok = 1'b1;
                break;
            end
            if (frame_done) stray++;
        end
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            int   cyc;
            int   stray;
            bit   ok;
            e = sb.pop_front();
            wait_change(cyc, stray, ok);
            if (!ok) begin
                n_total++;
                n_fail++;
                $error("FAIL an_timeout: an stuck at %0h, expected step to %0h", an, e.an);
            end
            check("an", an, e.an);
            check("seg", seg, e.seg);
            check("frame_done", frame_done, e.fd);
            check("pending", pending, e.pend);
            check("stray_frame_done", stray, 0);
            if (e.len_chk) check("slot_len", cyc, CLK_DIV);
            cur_an = e.an;
        end
    endtask

    initial begin
        int t;
        rst      = 1'b0;
        upd      = 1'b0;
        din      = 32'd0;
        blank_lz = 1'b0;
        cur_an   = 8'hFF;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_pending", pending, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);

        @(negedge clk);
        rst = 1'b1;
        step();
        check("first_an", an, 8'hFE);
        check("first_seg", seg, 7'h40);
        cur_an = 8'hFE;

        // Idle scan of zero
        push(32'd0, 1'b0, 1, 7, 1'b0, 1'b0);
        push(32'd0, 1'b0, 0, 7, 1'b0, 1'b1);
        drain(15);

        t = 0;
        while (!frame_done && t < 40) begin
            step();
            t++;
        end
        t = 0;
        do begin
            step();
            t++;
        end while (!frame_done && t < 40);
        check("frame_period", t, 8 * CLK_DIV);
        cur_an = 8'hFE;

        // Mid-frame update waits for the boundary
        din = 32'h1234ABCD;
        upd = 1'b1;
        step();
        upd = 1'b0;
        check("pend_set_mid", pending, 1'b1);
        push(32'd0, 1'b0, 1, 7, 1'b1, 1'b0);
        push(32'h1234ABCD, 1'b0, 0, 7, 1'b0, 1'b1);
        drain(15);

        // Two updates in one frame: last one wins
        push(32'h1234ABCD, 1'b0, 0, 0, 1'b0, 1'b1);
        drain(1);
        din = 32'h11111111;
        upd = 1'b1;
        step();
        upd = 1'b0;
        push(32'h1234ABCD, 1'b0, 1, 1, 1'b1, 1'b0);
        drain(1);
        din = 32'h00000009;
        upd = 1'b1;
        step();
        upd = 1'b0;
        push(32'h1234ABCD, 1'b0, 2, 7, 1'b1, 1'b0);
        push(32'h00000009, 1'b0, 0, 7, 1'b0, 1'b1);
        drain(14);

        // Update exactly in the boundary cycle
        repeat (CLK_DIV - 1) step();
        check("pre_boundary_an", an, 8'h7F);
        din = 32'hABCD0123;
        upd = 1'b1;
        step();
        upd = 1'b0;
        check("boundary_an", an, 8'hFE);
        check("boundary_seg", seg, ref_seg(32'hABCD0123, 0, 1'b0));
        check("boundary_pending", pending, 1'b0);
        check("boundary_frame_done", frame_done, 1'b1);
        cur_an = 8'hFE;
        push(32'hABCD0123, 1'b0, 1, 7, 1'b0, 1'b1);
        drain(7);

        // Leading-zero blanking
        blank_lz = 1'b1;
        din      = 32'h00000A05;
        upd      = 1'b1;
        step();
        upd = 1'b0;
        check("pend_set_blank", pending, 1'b1);
        push(32'h00000A05, 1'b1, 0, 7, 1'b0, 1'b0);
        drain(8);

        // Reset while a value is pending at digit 5
        push(32'h00000A05, 1'b1, 0, 5, 1'b0, 1'b1);
        drain(6);
        din = 32'h00005555;
        upd = 1'b1;
        step();
        upd = 1'b0;
        check("pend_set_d5", pending, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_an", an, 8'hFF);
        check("midrst_seg", seg, 7'h7F);
        check("midrst_pending", pending, 1'b0);
        check("midrst_frame_done", frame_done, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("rerelease_an", an, 8'hFE);
        check("rerelease_seg", seg, 7'h40);
        cur_an = 8'hFE;
        push(32'd0, 1'b1, 1, 7, 1'b0, 1'b0);
        push(32'd0, 1'b1, 0, 0, 1'b0, 1'b1);
        drain(8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
